// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-wide, big-endian data RAM.
// Checks alignment, extracts and extends sub-word loads, and performs SB/SH
// as a read-modify-write: one stalled read cycle, then one write cycle.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_store,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic [31:0]           load_data,
  output logic                  fault,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  ram_mem_write,
  output logic                  ram_mem_read,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic {IDLE = 1'b0, RMW_WRITE = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [31:0]           rmw_buf_q, rmw_buf_d;
  logic [31:0]           hold_wdata_q, hold_wdata_d;
  logic [ADDR_WIDTH-1:0] hold_waddr_q, hold_waddr_d;
  logic [1:0]            hold_off_q, hold_off_d;
  logic [1:0]            hold_size_q, hold_size_d;

  logic [ADDR_WIDTH-1:0] waddr;
  logic [1:0]            off;
  logic                  aligned;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_ext;
  logic [4:0]            mshift;
  logic [31:0]           lane_mask, lane_ins, merged;

  assign waddr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign off   = req_addr[1:0];

  // Alignment rule per access size; reserved size never passes.
  always_comb begin
    aligned = 1'b0;
    case (req_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Load lane select (big-endian: offset 0 is the MSB lane) and extension.
  // ~off gives 3-off, so {~off,3'b0} is the right shift to bring the lane down.
  always_comb begin
    ld_byte = 8'(ram_rdata >> {~off, 3'b000});
    ld_half = off[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    case (req_size)
      2'b00:   ld_ext = {{24{req_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{req_signed & ld_half[15]}}, ld_half};
      default: ld_ext = ram_rdata;
    endcase
  end

  // Merge the held store lane into the buffered RAM word.
  always_comb begin
    if (hold_size_q == 2'b00) begin
      mshift    = {~hold_off_q, 3'b000};
      lane_mask = 32'h0000_00FF << mshift;
      lane_ins  = {24'b0, hold_wdata_q[7:0]} << mshift;
    end else begin
      mshift    = {~hold_off_q[1], 4'b0000};
      lane_mask = 32'h0000_FFFF << mshift;
      lane_ins  = {16'b0, hold_wdata_q[15:0]} << mshift;
    end
    merged = (rmw_buf_q & ~lane_mask) | lane_ins;
  end

  // Next-state and output decode; everything is forced low while in reset.
  always_comb begin
    state_d       = state_q;
    rmw_buf_d     = rmw_buf_q;
    hold_wdata_d  = hold_wdata_q;
    hold_waddr_d  = hold_waddr_q;
    hold_off_d    = hold_off_q;
    hold_size_d   = hold_size_q;
    load_data     = 32'b0;
    fault         = 1'b0;
    stall         = 1'b0;
    ram_addr      = '0;
    ram_wdata     = 32'b0;
    ram_mem_write = 1'b0;
    ram_mem_read  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (!aligned) begin
              fault = 1'b1;
            end else if (!req_store) begin
              ram_mem_read = 1'b1;
              ram_addr     = waddr;
              load_data    = ld_ext;
            end else if (req_size == 2'b10) begin
              ram_mem_write = 1'b1;
              ram_addr      = waddr;
              ram_wdata     = req_wdata;
            end else begin
              ram_mem_read = 1'b1;
              ram_addr     = waddr;
              stall        = 1'b1;
              rmw_buf_d    = ram_rdata;
              hold_waddr_d = waddr;
              hold_off_d   = off;
              hold_size_d  = req_size;
              hold_wdata_d = req_wdata;
              state_d      = RMW_WRITE;
            end
          end
        end
        RMW_WRITE: begin
          ram_mem_write = 1'b1;
          ram_addr      = hold_waddr_q;
          ram_wdata     = merged;
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and RMW holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rmw_buf_q    <= 32'b0;
      hold_wdata_q <= 32'b0;
      hold_waddr_q <= '0;
      hold_off_q   <= 2'b0;
      hold_size_q  <= 2'b0;
    end else begin
      state_q      <= state_d;
      rmw_buf_q    <= rmw_buf_d;
      hold_wdata_q <= hold_wdata_d;
      hold_waddr_q <= hold_waddr_d;
      hold_off_q   <= hold_off_d;
      hold_size_q  <= hold_size_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array reference memory predicts
// every RAM transaction / load result; a negedge monitor classifies what the
// DUT presents each cycle and checks it against the expectation queue.
module tb_mem_access_unit;
  localparam int AW = 10;
  localparam int K_NONE = 0, K_LOAD = 1, K_WRITE = 2, K_RMWRD = 3, K_FAULT = 4, K_BAD = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_store = 1'b0, req_signed = 1'b0;
  logic [1:0]    req_size = 2'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'b0;
  logic [31:0]   load_data, ram_wdata, ram_rdata;
  logic          fault, stall, ram_mem_write, ram_mem_read;
  logic [AW-1:0] ram_addr;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .load_data(load_data), .fault(fault), .stall(stall),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_mem_write(ram_mem_write),
    .ram_mem_read(ram_mem_read), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Word-wide RAM seen by the DUT: combinational read, write at the edge.
  logic [31:0] ram [0:(1<<(AW-2))-1];
  assign ram_rdata = ram[ram_addr[AW-1:2]];
  always @(posedge clk) if (ram_mem_write) ram[ram_addr[AW-1:2]] <= ram_wdata;

  // Reference memory, byte addressed, big-endian.
  logic [7:0] refm [0:(1<<AW)-1];

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } ev_t;
  ev_t expq[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] ref_word(input int a);
    return {refm[a], refm[a+1], refm[a+2], refm[a+3]};
  endfunction

  // Present one request and record what the DUT must do for it.
  task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [AW-1:0] a, input logic [31:0] wd);
    int wa, ai;
    logic ok;
    logic [31:0] v;
    ai = int'(a);
    wa = ai - (ai % 4);
    ok = (sz == 2'd0) || (sz == 2'd1 && ai % 2 == 0) || (sz == 2'd2 && ai % 4 == 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    if (!ok) begin
      expq.push_back('{K_FAULT, '0, 32'b0});
    end else if (!st) begin
      if (sz == 2'd0) begin
        v = {24'b0, refm[ai]};
        if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        v = {16'b0, refm[ai], refm[ai+1]};
        if (sg && v[15]) v = v | 32'hFFFF_0000;
      end else begin
        v = ref_word(wa);
      end
      expq.push_back('{K_LOAD, AW'(wa), v});
    end else if (sz == 2'd2) begin
      {refm[wa], refm[wa+1], refm[wa+2], refm[wa+3]} = wd;
      expq.push_back('{K_WRITE, AW'(wa), wd});
    end else begin
      expq.push_back('{K_RMWRD, AW'(wa), 32'b0});
      if (sz == 2'd0) refm[ai] = wd[7:0];
      else {refm[ai], refm[ai+1]} = wd[15:0];
      expq.push_back('{K_WRITE, AW'(wa), ref_word(wa)});
      @(posedge clk); #1;   // pipeline held during the stall cycle
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0; req_store = 1'($urandom); req_size = 2'($urandom);
    req_addr = AW'($urandom); req_wdata = $urandom;
  endtask

  // Monitor: classify each cycle's DUT activity and compare to the scoreboard.
  always @(negedge clk) begin
    int k;
    logic [AW-1:0] oa;
    logic [31:0] od;
    ev_t e;
    if (rst) begin
      n_cmp++;
      if (load_data != 0 || fault || stall || ram_addr != 0 || ram_wdata != 0 ||
          ram_mem_write || ram_mem_read) begin
        n_bad++;
        $display("FAIL reset_outputs: got ld=%h f=%b st=%b a=%h wd=%h we=%b re=%b, need all 0",
                 load_data, fault, stall, ram_addr, ram_wdata, ram_mem_write, ram_mem_read);
      end
    end else begin
      oa = ram_addr;
      od = 32'b0;
      if (fault) begin
        k  = (!ram_mem_read && !ram_mem_write && !stall && load_data == 0) ? K_FAULT : K_BAD;
        oa = '0;
      end else if (ram_mem_read && ram_mem_write) k = K_BAD;
      else if (ram_mem_read) begin
        if (stall) k = (load_data == 0) ? K_RMWRD : K_BAD;
        else begin k = K_LOAD; od = load_data; end
      end else if (ram_mem_write) begin
        k  = (!stall && load_data == 0) ? K_WRITE : K_BAD;
        od = ram_wdata;
      end else k = K_NONE;

      if (k == K_NONE) begin
        n_cmp++;
        if (stall || load_data != 0) begin
          n_bad++;
          $display("FAIL idle_outputs: got stall=%b ld=%h, need 0/0", stall, load_data);
        end
      end else if (expq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, need nothing", k, oa, od);
      end else begin
        e = expq.pop_front();
        n_cmp++;
        if (k != e.kind || oa != e.addr || od != e.data) begin
          n_bad++;
          $display("FAIL event: got kind=%0d addr=%h data=%h, need kind=%0d addr=%h data=%h",
                   k, oa, od, e.kind, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << (AW-2)); i++) ram[i] = $urandom;
    ram[5] = 32'h80F0_A5C3;   // bytes 0x014..0x017
    ram[4] = 32'h1122_3344;   // bytes 0x010..0x013
    for (int i = 0; i < (1 << (AW-2)); i++)
      {refm[4*i], refm[4*i+1], refm[4*i+2], refm[4*i+3]} = ram[i];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle();

    // Sub-word and word loads with extension
    issue(0, 2'd0, 1, 10'h015, 0);   // LB  -> FFFFFFF0
    issue(0, 2'd0, 0, 10'h015, 0);   // LBU -> 000000F0
    issue(0, 2'd1, 1, 10'h016, 0);   // LH  -> FFFFA5C3
    issue(0, 2'd1, 0, 10'h014, 0);   // LHU -> 000080F0
    issue(0, 2'd2, 0, 10'h014, 0);   // LW  -> 80F0A5C3
    // SB read-modify-write then readback
    issue(1, 2'd0, 0, 10'h012, 32'h0000_00AB);
    issue(0, 2'd2, 0, 10'h010, 0);   // -> 1122AB44
    // Back-to-back SH/SB on a restored word
    issue(1, 2'd2, 0, 10'h010, 32'h1122_3344);
    issue(1, 2'd1, 0, 10'h010, 32'h0000_BEEF);
    issue(1, 2'd0, 0, 10'h013, 32'h0000_0077);
    issue(0, 2'd2, 0, 10'h010, 0);   // -> BEEF3377
    // Faults: misaligned word, misaligned half, reserved size
    issue(0, 2'd2, 0, 10'h012, 0);
    issue(1, 2'd1, 0, 10'h013, 32'h1234_5678);
    issue(1, 2'd3, 0, 10'h010, 32'hFFFF_FFFF);
    issue(0, 2'd2, 0, 10'h010, 0);   // unchanged

    // Reset during the write half of an SB aborts the write
    @(posedge clk); #1;
    req_valid = 1; req_store = 1; req_size = 2'd0; req_signed = 0;
    req_addr = 10'h011; req_wdata = 32'h0000_0055;
    expq.push_back('{K_RMWRD, 10'h010, 32'b0});
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    #1;
    n_cmp++;
    if (ram_mem_write || stall) begin
      n_bad++;
      $display("FAIL rst_abort: got we=%b stall=%b, need 0/0", ram_mem_write, stall);
    end
    @(posedge clk); #1 rst = 1'b0;
    idle();
    issue(0, 2'd2, 0, 10'h010, 0);   // word 0x010 untouched

    // SW then byte readback
    issue(1, 2'd2, 0, 10'h020, 32'hDEAD_BEEF);
    issue(0, 2'd0, 0, 10'h023, 0);   // -> 000000EF

    // Randomized traffic over a small window so stores and loads collide
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) idle();
      else issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                 AW'($urandom_range(0, 63)), $urandom);
    end
    for (int a = 0; a < 64; a += 4) issue(0, 2'd2, 0, AW'(a), 0);

    idle();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending events, need 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit, directly upstream of the byte-addressed, big-endian data RAM.
- Takes pipeline load/store requests and enforces MIPS alignment rules.
- Extracts and sign/zero-extends byte and halfword loads.
- Turns SB/SH into a two-cycle read-modify-write, because the RAM writes only full 4-byte words.
- Raises `stall` to the hazard unit while an RMW is in progress.

Parameters:
- ADDR_WIDTH, 10, byte-address width shared with the data RAM.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM-stage instruction is a memory op
- req_store  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved
- req_signed  in  1  loads: 1=sign-extend (LB/LH), 0=zero-extend (LBU/LHU)
- req_addr  in  ADDR_WIDTH  byte address from ALU
- req_wdata  in  32  store data (right-justified for SB/SH)
- load_data  out  32  extended load result to MEM/WB
- fault  out  1  misaligned or reserved-size request; access suppressed
- stall  out  1  hold IF/ID/EX/MEM registers this cycle
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  32  RAM write data
- ram_mem_write  out  1  RAM write enable
- ram_mem_read  out  1  RAM read enable
- ram_rdata  in  32  RAM combinational read data (big-endian word)

Behaviour:
- Word-aligned address: `waddr = req_addr & ~3`.
- Byte lane, big-endian: offset 0 maps to bits [31:24], offset 3 to bits [7:0].
- Half lane: offset 0 maps to bits [31:16], offset 2 to bits [15:0].
- Alignment check:
  - word requires `addr[1:0]==0`
  - half requires `addr[0]==0`
  - byte is always aligned
  - `req_size=11` always faults
- Fault: in IDLE with `req_valid` and a failed alignment check, `fault=1` combinationally.
  - No RAM enable, `load_data=0`, `stall=0`, state unchanged.
- FSM, two states, IDLE and RMW_WRITE:
  - IDLE, no `req_valid`: all RAM enables 0, `load_data=0`, `stall=0`.
  - IDLE, aligned load: `ram_mem_read=1`, `ram_addr=waddr`.
    - `load_data` is the selected lane of `ram_rdata`, extended per `req_signed`. Word loads pass through.
    - Zero latency, no stall.
  - IDLE, aligned SW: `ram_mem_write=1`, `ram_addr=waddr`, `ram_wdata=req_wdata`. Completes at this edge, no stall.
  - IDLE, aligned SB/SH: `ram_mem_read=1`, `ram_addr=waddr`, `stall=1`.
    - At the edge: latch `ram_rdata` into `rmw_buf`, and latch waddr, offset, size and wdata into `hold_*` registers.
    - Go to RMW_WRITE.
  - RMW_WRITE: `ram_mem_write=1`, `ram_addr=hold_waddr`.
    - `ram_wdata` = `rmw_buf` with the selected lane replaced by `hold_wdata[7:0]` or `[15:0]`. Other lanes unchanged.
    - `stall=0`; the pipeline advances at this edge. Return to IDLE.
    - Request inputs are ignored in this state; only `hold_*` is used.
- Sub-word store cost: 2 cycles, exactly 1 stall cycle.
- Back-to-back SB/SH: the second request is seen in IDLE on the cycle after RMW_WRITE and starts a fresh RMW, reading memory already updated.
- Outputs are never X. `load_data` is 0 whenever no load is served.
- Reset (asynchronous):
  - state→IDLE; `rmw_buf` and `hold_*` →0.
  - While `rst=1`, all outputs are 0, including `stall` and `fault`.
  - Reset asserted during RMW_WRITE aborts the write: `ram_mem_write` drops immediately and memory is unchanged.

Test Plan:
- RAM[0x014..0x017]=0x80F0A5C3. LB 0x015 → 0xFFFFFFF0. LBU 0x015 → 0x000000F0. LH 0x016 → 0xFFFFA5C3. LHU 0x014 → 0x000080F0. LW 0x014 → 0x80F0A5C3. No stall on any.
- RAM word 0x010=0x11223344; SB 0x012, wdata 0x000000AB:
  - cycle 0: `stall=1`, `ram_mem_read=1`
  - cycle 1: `ram_mem_write=1`, `ram_wdata=0x1122AB44`
  - then LW 0x010 → 0x1122AB44
- SH 0x010 wdata 0x0000BEEF, then SB 0x013 wdata 0x77 back-to-back → 2 stall cycles total; LW 0x010 → 0xBEEF3377.
- LW 0x012, then SH 0x013, then req_size=11 at 0x010 → `fault=1` each cycle, RAM enables 0, `stall=0`, RAM contents unchanged.
- SB 0x011 with `rst` pulsed during RMW_WRITE → `ram_mem_write` deasserts asynchronously, word 0x010 unchanged, state IDLE, `stall=0` after release.
- SW 0x020 wdata 0xDEADBEEF → single-cycle write, `stall=0`; LBU 0x023 → 0x000000EF.
